// File: rtl/operand_fwd_if.sv
// Bundle between the ID/EX/DM pipeline control and the operand forwarding unit.
// The master drives the ID-stage fields and stage results; the slave returns operands and hazard status.
interface operand_fwd_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16,
    parameter int NUM_RD = 2
);
    logic                       stall_ID_EX;
    logic                       stall_EX_DM;
    logic                       flush_ID_EX;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr_ID;
    logic [NUM_RD*DATA_W-1:0]   rd_data_ID;
    logic [NUM_RD-1:0]          rd_used_ID;
    logic [NUM_RD*2-1:0]        srcsel_ID;
    logic [IMM_W-1:0]           imm_ID;
    logic [DATA_W-1:0]          pc_ID;
    logic [ADDR_W-1:0]          dst_addr_ID;
    logic                       we_ID;
    logic                       ld_ID;
    logic [DATA_W-1:0]          dst_EX_DM;
    logic [DATA_W-1:0]          dst_DM_WB;
    logic [NUM_RD*DATA_W-1:0]   src;
    logic [DATA_W-1:0]          p0_EX_DM;
    logic                       load_use_stall;
    logic [NUM_RD-1:0]          byp_EX;
    logic [NUM_RD-1:0]          byp_DM;

    modport master (
        output stall_ID_EX, stall_EX_DM, flush_ID_EX, rd_addr_ID, rd_data_ID, rd_used_ID,
               srcsel_ID, imm_ID, pc_ID, dst_addr_ID, we_ID, ld_ID, dst_EX_DM, dst_DM_WB,
        input  src, p0_EX_DM, load_use_stall, byp_EX, byp_DM
    );

    modport slave (
        input  stall_ID_EX, stall_EX_DM, flush_ID_EX, rd_addr_ID, rd_data_ID, rd_used_ID,
               srcsel_ID, imm_ID, pc_ID, dst_addr_ID, we_ID, ld_ID, dst_EX_DM, dst_DM_WB,
        output src, p0_EX_DM, load_use_stall, byp_EX, byp_DM
    );
endinterface

// File: rtl/operand_fwd_unit.sv
// EX-stage operand delivery with self-generated bypass selects, load-use detection and store-data pipelining.
// Optional RF_WT_BYP_EN: capture the DM/WB result at ID/EX when the register file is not write-before-read.
module operand_fwd_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int IMM_W  = 16,
    parameter int NUM_RD = 2
) (
    input  logic          clk,
    input  logic          rst,
    operand_fwd_if.slave  bus
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_r;
    logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr_r;
    logic [NUM_RD-1:0]             used_r;
    logic [NUM_RD-1:0][1:0]        sel_r;
    logic [IMM_W-1:0]              imm_r;
    logic [DATA_W-1:0]             pc_r;
    logic [ADDR_W-1:0]             dst_ex_r;
    logic                          we_ex_r;
    logic                          ld_ex_r;
    logic [ADDR_W-1:0]             dst_dm_r;
    logic                          we_dm_r;
    logic                          ld_dm_r;
    logic [ADDR_W-1:0]             dst_wb_r;
    logic                          we_wb_r;
    logic [DATA_W-1:0]             p0_r;

    logic [NUM_RD-1:0][DATA_W-1:0] cap_data_s;
    logic [NUM_RD-1:0][DATA_W-1:0] fwd_s;
    logic [NUM_RD-1:0][DATA_W-1:0] src_s;
    logic [NUM_RD-1:0]             byp_ex_s;
    logic [NUM_RD-1:0]             byp_dm_s;
    logic                          load_use_s;

    // Read data captured at ID/EX, optionally overridden by the value being written back this cycle.
    always_comb begin
        cap_data_s = '0;
        for (int k = 0; k < NUM_RD; k++) begin
`ifdef RF_WT_BYP_EN
            if (we_wb_r && (dst_wb_r != ZERO_ADDR) &&
                (bus.rd_addr_ID[k*ADDR_W +: ADDR_W] == dst_wb_r)) begin
                cap_data_s[k] = bus.dst_DM_WB;
            end else begin
                cap_data_s[k] = bus.rd_data_ID[k*DATA_W +: DATA_W];
            end
`else
            cap_data_s[k] = bus.rd_data_ID[k*DATA_W +: DATA_W];
`endif
        end
    end

    // ID/EX register: data fields follow the stall, control fields are cleared by a flush even when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_r <= '0;
            rd_addr_r <= '0;
            used_r    <= '0;
            sel_r     <= '0;
            imm_r     <= '0;
            pc_r      <= '0;
            dst_ex_r  <= '0;
            we_ex_r   <= 1'b0;
            ld_ex_r   <= 1'b0;
        end else begin
            if (!bus.stall_ID_EX) begin
                rd_data_r <= cap_data_s;
                rd_addr_r <= bus.rd_addr_ID;
                imm_r     <= bus.imm_ID;
                pc_r      <= bus.pc_ID;
                dst_ex_r  <= bus.dst_addr_ID;
            end
            if (bus.flush_ID_EX) begin
                used_r  <= '0;
                sel_r   <= '0;
                we_ex_r <= 1'b0;
                ld_ex_r <= 1'b0;
            end else if (!bus.stall_ID_EX) begin
                used_r  <= bus.rd_used_ID;
                sel_r   <= bus.srcsel_ID;
                we_ex_r <= bus.we_ID;
                ld_ex_r <= bus.ld_ID;
            end
        end
    end

    // Destination tracking through EX/DM and DM/WB, plus the store-data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_dm_r <= '0;
            we_dm_r  <= 1'b0;
            ld_dm_r  <= 1'b0;
            dst_wb_r <= '0;
            we_wb_r  <= 1'b0;
            p0_r     <= '0;
        end else if (!bus.stall_EX_DM) begin
            dst_dm_r <= dst_ex_r;
            we_dm_r  <= we_ex_r;
            ld_dm_r  <= ld_ex_r;
            dst_wb_r <= dst_dm_r;
            we_wb_r  <= we_dm_r;
            p0_r     <= fwd_s[0];
        end
    end

    // Bypass detection and operand selection; a load at EX/DM has no data yet, so it never feeds byp_EX.
    always_comb begin
        byp_ex_s = '0;
        byp_dm_s = '0;
        fwd_s    = '0;
        src_s    = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            byp_ex_s[k] = used_r[k] && we_dm_r && !ld_dm_r &&
                          (rd_addr_r[k] != ZERO_ADDR) && (rd_addr_r[k] == dst_dm_r);
            byp_dm_s[k] = used_r[k] && we_wb_r &&
                          (rd_addr_r[k] != ZERO_ADDR) && (rd_addr_r[k] == dst_wb_r);
            if (byp_ex_s[k]) begin
                fwd_s[k] = bus.dst_EX_DM;
            end else if (byp_dm_s[k]) begin
                fwd_s[k] = bus.dst_DM_WB;
            end else begin
                fwd_s[k] = rd_data_r[k];
            end
            case (sel_r[k])
                2'd0:    src_s[k] = fwd_s[k];
                2'd1:    src_s[k] = DATA_W'($signed(imm_r));
                2'd2:    src_s[k] = DATA_W'(imm_r);
                2'd3:    src_s[k] = pc_r;
                default: src_s[k] = fwd_s[k];
            endcase
        end
    end

    // Load-use hazard between the ID-stage readers and a load sitting in ID/EX.
    always_comb begin
        load_use_s = 1'b0;
        for (int k = 0; k < NUM_RD; k++) begin
            if (bus.rd_used_ID[k] && ld_ex_r && we_ex_r && (dst_ex_r != ZERO_ADDR) &&
                (bus.rd_addr_ID[k*ADDR_W +: ADDR_W] == dst_ex_r)) begin
                load_use_s = 1'b1;
            end else begin
                load_use_s = load_use_s;
            end
        end
    end

    assign bus.src            = src_s;
    assign bus.byp_EX         = byp_ex_s;
    assign bus.byp_DM         = byp_dm_s;
    assign bus.load_use_stall = load_use_s;
    assign bus.p0_EX_DM       = p0_r;

endmodule

// File: tb/tb_operand_fwd_unit.sv
// Self-checking bench for operand_fwd_unit: directed table, hazard sequences and a randomized model comparison.
module tb_operand_fwd_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int IW = 16;
    localparam int NR = 2;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    operand_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .IMM_W(IW), .NUM_RD(NR)) bus ();

    operand_fwd_unit #(.DATA_W(DW), .ADDR_W(AW), .IMM_W(IW), .NUM_RD(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef RF_WT_BYP_EN
    localparam bit WT_EN = 1'b1;
`else
    localparam bit WT_EN = 1'b0;
`endif

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] imm;
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];

    // Reference model: one ID/EX entry plus the destinations of the two older in-flight instructions.
    logic [31:0] m_data [2];
    logic [4:0]  m_addr [2];
    logic        m_used [2];
    logic [1:0]  m_sel  [2];
    logic [15:0] m_imm;
    logic [31:0] m_pc;
    logic [4:0]  m_dst;
    logic        m_we;
    logic        m_ld;
    logic [4:0]  m_pdst [1:2];
    logic        m_pwe  [1:2];
    logic        m_pld  [1:2];
    logic [31:0] m_p0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall_ID_EX = 1'b0;
        bus.stall_EX_DM = 1'b0;
        bus.flush_ID_EX = 1'b0;
        bus.rd_addr_ID  = '0;
        bus.rd_data_ID  = '0;
        bus.rd_used_ID  = '0;
        bus.srcsel_ID   = '0;
        bus.imm_ID      = '0;
        bus.pc_ID       = '0;
        bus.dst_addr_ID = '0;
        bus.we_ID       = 1'b0;
        bus.ld_ID       = 1'b0;
        bus.dst_EX_DM   = '0;
        bus.dst_DM_WB   = '0;
    endtask

    task automatic drain();
        idle();
        repeat (3) step();
    endtask

    task automatic set_p0(input logic [4:0] a, input logic [31:0] d, input logic u, input logic [1:0] s);
        bus.rd_addr_ID[4:0]  = a;
        bus.rd_data_ID[31:0] = d;
        bus.rd_used_ID[0]    = u;
        bus.srcsel_ID[1:0]   = s;
    endtask

    task automatic producer(input logic [4:0] d, input logic is_ld);
        idle();
        bus.dst_addr_ID = d;
        bus.we_ID       = 1'b1;
        bus.ld_ID       = is_ld;
    endtask

    function automatic logic m_hit(input int k, input int d);
        return m_used[k] && (m_addr[k] != 5'd0) && m_pwe[d] && (m_pdst[d] == m_addr[k]) &&
               !((d == 1) && m_pld[d]);
    endfunction

    function automatic logic [31:0] m_fwd(input int k);
        for (int d = 1; d <= 2; d++) begin
            if (m_hit(k, d)) return (d == 1) ? bus.dst_EX_DM : bus.dst_DM_WB;
        end
        return m_data[k];
    endfunction

    function automatic logic [31:0] m_operand(input int k);
        case (m_sel[k])
            2'd1:    return {{16{m_imm[15]}}, m_imm};
            2'd2:    return {16'h0000, m_imm};
            2'd3:    return m_pc;
            default: return m_fwd(k);
        endcase
    endfunction

    function automatic logic m_lus();
        logic r;
        r = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (bus.rd_used_ID[k] && m_ld && m_we && (m_dst != 5'd0) &&
                (bus.rd_addr_ID[k*AW +: AW] == m_dst)) r = 1'b1;
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int k = 0; k < NR; k++) begin
            m_data[k] = '0; m_addr[k] = '0; m_used[k] = 1'b0; m_sel[k] = '0;
        end
        m_imm = '0; m_pc = '0; m_dst = '0; m_we = 1'b0; m_ld = 1'b0; m_p0 = '0;
        for (int d = 1; d <= 2; d++) begin
            m_pdst[d] = '0; m_pwe[d] = 1'b0; m_pld[d] = 1'b0;
        end
    endtask

    task automatic m_clock();
        logic [31:0] f0;
        logic [31:0] cap [2];
        f0 = m_fwd(0);
        for (int k = 0; k < NR; k++) begin
            cap[k] = bus.rd_data_ID[k*DW +: DW];
            if (WT_EN && m_pwe[2] && (m_pdst[2] != 5'd0) && (bus.rd_addr_ID[k*AW +: AW] == m_pdst[2]))
                cap[k] = bus.dst_DM_WB;
        end
        if (!bus.stall_EX_DM) begin
            m_pdst[2] = m_pdst[1]; m_pwe[2] = m_pwe[1]; m_pld[2] = m_pld[1];
            m_pdst[1] = m_dst;     m_pwe[1] = m_we;     m_pld[1] = m_ld;
            m_p0 = f0;
        end
        if (!bus.stall_ID_EX) begin
            for (int k = 0; k < NR; k++) begin
                m_data[k] = cap[k];
                m_addr[k] = bus.rd_addr_ID[k*AW +: AW];
                m_used[k] = bus.rd_used_ID[k];
                m_sel[k]  = bus.srcsel_ID[k*2 +: 2];
            end
            m_imm = bus.imm_ID; m_pc = bus.pc_ID; m_dst = bus.dst_addr_ID;
            m_we = bus.we_ID; m_ld = bus.ld_ID;
        end
        if (bus.flush_ID_EX) begin
            for (int k = 0; k < NR; k++) begin
                m_used[k] = 1'b0; m_sel[k] = 2'd0;
            end
            m_we = 1'b0; m_ld = 1'b0;
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        vecs[0] = '{sel: 2'd0, imm: 16'h0000, pc: 32'h0,        data: 32'hCAFEF00D, exp: 32'hCAFEF00D};
        vecs[1] = '{sel: 2'd1, imm: 16'h8001, pc: 32'h0,        data: 32'h12345678, exp: 32'hFFFF8001};
        vecs[2] = '{sel: 2'd2, imm: 16'h8001, pc: 32'h0,        data: 32'h12345678, exp: 32'h00008001};
        vecs[3] = '{sel: 2'd3, imm: 16'h8001, pc: 32'h00000400, data: 32'h12345678, exp: 32'h00000400};
        vecs[4] = '{sel: 2'd1, imm: 16'h7FFF, pc: 32'h0,        data: 32'h0,        exp: 32'h00007FFF};
        vecs[5] = '{sel: 2'd2, imm: 16'hFFFF, pc: 32'h0,        data: 32'h0,        exp: 32'h0000FFFF};

        // Reset values, then one-cycle operand latency.
        rst = 1'b1;
        idle();
        set_p0(5'd1, 32'h1234, 1'b1, 2'd0);
        #12;
        chk("rst_src", 64'(bus.src), 64'd0);
        chk("rst_p0", 64'(bus.p0_EX_DM), 64'd0);
        chk("rst_lus", 64'(bus.load_use_stall), 64'd0);
        chk("rst_byp", 64'({bus.byp_EX, bus.byp_DM}), 64'd0);
        rst = 1'b0;
        #1;
        chk("pre_edge_src0", 64'(bus.src[31:0]), 64'd0);
        step();
        chk("latency_src0", 64'(bus.src[31:0]), 64'h1234);

        // Distance-1 ALU producer.
        drain();
        producer(5'd3, 1'b0);
        step();
        idle();
        set_p0(5'd3, 32'h0BAD, 1'b1, 2'd0);
        bus.dst_EX_DM = 32'hAAAA5555;
        step();
        chk("d1_bypEX", 64'(bus.byp_EX[0]), 64'd1);
        chk("d1_src", 64'(bus.src[31:0]), 64'hAAAA5555);

        // Distance-2 producer.
        drain();
        producer(5'd3, 1'b0);
        step();
        idle();
        step();
        set_p0(5'd3, 32'h0BAD, 1'b1, 2'd0);
        bus.dst_EX_DM = 32'h12345678;
        bus.dst_DM_WB = 32'h77;
        step();
        chk("d2_bypDM", 64'({bus.byp_EX[0], bus.byp_DM[0]}), 64'b01);
        chk("d2_src", 64'(bus.src[31:0]), 64'h77);

        // EX/DM wins over DM/WB.
        drain();
        producer(5'd3, 1'b0);
        step();
        step();
        idle();
        set_p0(5'd3, 32'h0BAD, 1'b1, 2'd0);
        bus.dst_EX_DM = 32'h1;
        bus.dst_DM_WB = 32'h2;
        step();
        chk("prio_src", 64'(bus.src[31:0]), 64'h1);

        // Load-use: stall for one cycle, bubble, then load data arrives via DM/WB.
        drain();
        producer(5'd5, 1'b1);
        step();
        idle();
        set_p0(5'd5, 32'h0BAD, 1'b1, 2'd0);
        #1;
        chk("lu_stall", 64'(bus.load_use_stall), 64'd1);
        bus.flush_ID_EX = 1'b1;
        step();
        chk("lu_stall_once", 64'(bus.load_use_stall), 64'd0);
        bus.flush_ID_EX = 1'b0;
        bus.dst_EX_DM = 32'hFFFF0000;
        bus.dst_DM_WB = 32'hDEAD;
        step();
        chk("lu_byp", 64'({bus.byp_EX[0], bus.byp_DM[0]}), 64'b01);
        chk("lu_src", 64'(bus.src[31:0]), 64'hDEAD);

        // r0 never stalls or forwards.
        drain();
        producer(5'd0, 1'b1);
        step();
        idle();
        set_p0(5'd0, 32'h0BAD, 1'b1, 2'd0);
        #1;
        chk("r0_stall", 64'(bus.load_use_stall), 64'd0);
        drain();
        producer(5'd0, 1'b0);
        step();
        idle();
        set_p0(5'd0, 32'h0BAD, 1'b1, 2'd0);
        bus.dst_EX_DM = 32'hAAAA;
        step();
        chk("r0_byp", 64'({bus.byp_EX[0], bus.byp_DM[0]}), 64'd0);
        chk("r0_src", 64'(bus.src[31:0]), 64'h0BAD);

        // Operand select table, both ports.
        drain();
        for (int i = 0; i < 6; i++) begin
            bus.srcsel_ID  = {vecs[i].sel, vecs[i].sel};
            bus.imm_ID     = vecs[i].imm;
            bus.pc_ID      = vecs[i].pc;
            bus.rd_data_ID = {vecs[i].data, vecs[i].data};
            step();
            chk($sformatf("sel_vec%0d", i), 64'(bus.src), {vecs[i].exp, vecs[i].exp});
        end

        // Distance-3 producer against stale register-file data.
        drain();
        producer(5'd7, 1'b0);
        step();
        idle();
        step();
        step();
        set_p0(5'd7, 32'h11, 1'b1, 2'd0);
        bus.dst_DM_WB = 32'h99;
        step();
        bus.dst_DM_WB = 32'h5555;
        #1;
        chk("d3_byp", 64'({bus.byp_EX[0], bus.byp_DM[0]}), 64'd0);
        chk("d3_src", 64'(bus.src[31:0]), WT_EN ? 64'h99 : 64'h11);

        // Pipeline hold freezes store data and operands.
        drain();
        set_p0(5'd0, 32'h5A5A, 1'b0, 2'd0);
        step();
        step();
        chk("p0_load", 64'(bus.p0_EX_DM), 64'h5A5A);
        bus.stall_ID_EX = 1'b1;
        bus.stall_EX_DM = 1'b1;
        bus.rd_data_ID[31:0] = 32'h1111;
        bus.dst_EX_DM = 32'h3333;
        step();
        step();
        chk("hold_p0", 64'(bus.p0_EX_DM), 64'h5A5A);
        chk("hold_src", 64'(bus.src[31:0]), 64'h5A5A);
        bus.stall_ID_EX = 1'b0;
        bus.stall_EX_DM = 1'b0;
        step();
        chk("release_p0", 64'(bus.p0_EX_DM), 64'h5A5A);
        chk("release_src", 64'(bus.src[31:0]), 64'h1111);
        step();
        chk("release_p0_next", 64'(bus.p0_EX_DM), 64'h1111);

        // Reset during a stall with hazards in flight.
        drain();
        producer(5'd4, 1'b0);
        step();
        idle();
        set_p0(5'd4, 32'h0BAD, 1'b1, 2'd0);
        bus.dst_EX_DM = 32'hABCD;
        step();
        producer(5'd4, 1'b1);
        set_p0(5'd4, 32'h0BAD, 1'b1, 2'd0);
        bus.stall_ID_EX = 1'b1;
        bus.stall_EX_DM = 1'b1;
        bus.dst_EX_DM = 32'hABCD;
        step();
        rst = 1'b1;
        #1;
        chk("mid_rst_src", 64'(bus.src), 64'd0);
        chk("mid_rst_flags", 64'({bus.byp_EX, bus.byp_DM, bus.load_use_stall}), 64'd0);
        chk("mid_rst_p0", 64'(bus.p0_EX_DM), 64'd0);
        #2;
        rst = 1'b0;

        // Randomized run against the reference model.
        idle();
        rst = 1'b1;
        step();
        m_reset();
        rst = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < NR; k++) begin
                bus.rd_addr_ID[k*AW +: AW] = 5'($urandom_range(0, 3));
                bus.rd_data_ID[k*DW +: DW] = $urandom;
                bus.rd_used_ID[k]          = 1'($urandom_range(0, 1));
                bus.srcsel_ID[k*2 +: 2]    = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
            end
            bus.imm_ID      = 16'($urandom);
            bus.pc_ID       = $urandom;
            bus.dst_addr_ID = 5'($urandom_range(0, 3));
            bus.we_ID       = 1'($urandom_range(0, 1));
            bus.ld_ID       = ($urandom_range(0, 2) == 0);
            bus.dst_EX_DM   = $urandom;
            bus.dst_DM_WB   = $urandom;
            bus.stall_ID_EX = ($urandom_range(0, 7) == 0);
            bus.stall_EX_DM = bus.stall_ID_EX && ($urandom_range(0, 1) == 1);
            bus.flush_ID_EX = ($urandom_range(0, 7) == 0);
            #1;
            chk("rnd_src", 64'(bus.src), {m_operand(1), m_operand(0)});
            chk("rnd_bypEX", 64'(bus.byp_EX), 64'({m_hit(1, 1), m_hit(0, 1)}));
            chk("rnd_bypDM", 64'(bus.byp_DM), 64'({m_hit(1, 2), m_hit(0, 2)}));
            chk("rnd_p0", 64'(bus.p0_EX_DM), 64'(m_p0));
            chk("rnd_lus", 64'(bus.load_use_stall), 64'(m_lus()));
            m_clock();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
